// File: rtl/pattern_serializer_pkg.sv
// rtl/pattern_serializer_pkg.sv - shared types and pair-detector transition function
package pattern_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ser_state_t;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;

    // S11 means "just closed a pair of equal bits"; it restarts pairing from the next bit.
    function automatic logic [1:0] next_pair_state(input logic [1:0] s, input logic b);
        logic [1:0] n;
        n = S00;
        case (s)
            S00:     n = b ? S01 : S10;
            S01:     n = b ? S11 : S10;
            S10:     n = b ? S01 : S11;
            default: n = b ? S01 : S10;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pattern_serializer_pair_mirror.sv
// rtl/pattern_serializer_pair_mirror.sv - mirror of the receiver pair detector with hit counter
module pair_mirror
    import pattern_serializer_pkg::*;
#(
    parameter int HIT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [HIT_W-1:0] hits
);

    logic [1:0] state;
    logic [1:0] nxt;

    assign nxt = next_pair_state(state, din);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S00;
            hits  <= '0;
        end else if (clr) begin
            state <= S00;
            hits  <= '0;
        end else if (en) begin
            state <= nxt;
            if (nxt == S11) begin
                hits <= hits + HIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_serializer.sv
// rtl/pattern_serializer.sv - LSB-first word serializer with expected pair-detect hit count
module pattern_serializer
    import pattern_serializer_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int HIT_W = $clog2(WIDTH/2 + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             frame_start,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [HIT_W-1:0] hits
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    ser_state_t       state;
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;

    // x is a registered copy of the bit on the wire, so the mirror sees exactly what the receiver sees.
    pair_mirror #(.HIT_W(HIT_W)) u_mirror (
        .clock (clock),
        .reset (reset),
        .clr   (state == START),
        .en    (state == SHIFT),
        .din   (x),
        .hits  (hits)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            load_ready  <= 1'b0;
            frame_start <= 1'b0;
            x           <= 1'b0;
            x_valid     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    load_ready <= 1'b1;
                    if (load_valid && load_ready) begin
                        sr          <= load_data;
                        state       <= START;
                        load_ready  <= 1'b0;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                START: begin
                    frame_start <= 1'b0;
                    x           <= sr[0];
                    x_valid     <= 1'b1;
                    sr          <= sr >> 1;
                    cnt         <= '0;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        x  <= sr[0];
                        sr <= sr >> 1;
                    end
                end
                default: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// tb/tb_pattern_serializer.sv - randomized self-checking bench for pattern_serializer
module tb_pattern_serializer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_data = 8'h00;
    logic       frame_start;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;
    logic [2:0] hits;

    int total  = 0;
    int passed = 0;

    pattern_serializer #(.WIDTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .frame_start (frame_start),
        .x           (x),
        .x_valid     (x_valid),
        .busy        (busy),
        .done        (done),
        .hits        (hits)
    );

    always #5 clock = ~clock;

    // Greedy count of non-overlapping pairs of equal consecutive bits, LSB first.
    function automatic int model_hits(input logic [7:0] w);
        int n = 0;
        int i = 0;
        while (i < 7) begin
            if (w[i] == w[i+1]) begin
                n++;
                i += 2;
            end else begin
                i++;
            end
        end
        return n;
    endfunction

    task automatic wait_ready(input string name);
        int k = 0;
        while (load_ready !== 1'b1 && k < 30) begin
            @(negedge clock);
            k++;
        end
        if (load_ready !== 1'b1) begin
            total++;
            $display("FAIL %s ready_timeout: load_ready=%b after %0d cycles, want 1", name, load_ready, k);
        end
    endtask

    task automatic do_frame(input logic [7:0] w, input string name);
        int exp_hits;
        exp_hits = model_hits(w);
        wait_ready(name);
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clock);
        load_valid = 1'b0;
        load_data  = 8'($urandom);
        total++;
        if ({frame_start, x_valid, x, busy, load_ready} !== 5'b10010)
            $display("FAIL %s start: fs/xv/x/busy/rdy=%b want 10010", name, {frame_start, x_valid, x, busy, load_ready});
        else passed++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            total++;
            if ({x_valid, x, busy, done, frame_start} !== {1'b1, w[i], 1'b1, 1'b0, 1'b0})
                $display("FAIL %s bit%0d: xv/x/busy/done/fs=%b want %b", name, i,
                         {x_valid, x, busy, done, frame_start}, {1'b1, w[i], 3'b100});
            else passed++;
        end
        @(negedge clock);
        total++;
        if ({done, x_valid, x, busy} !== 4'b1001 || hits !== 3'(exp_hits))
            $display("FAIL %s done: done/xv/x/busy=%b hits=%0d want 1001 hits=%0d", name,
                     {done, x_valid, x, busy}, hits, exp_hits);
        else passed++;
        @(negedge clock);
        total++;
        if ({done, busy, load_ready} !== 3'b001 || hits !== 3'(exp_hits))
            $display("FAIL %s after: done/busy/rdy=%b hits=%0d want 001 hits=%0d", name,
                     {done, busy, load_ready}, hits, exp_hits);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if ({load_ready, frame_start, x, x_valid, busy, done} !== 6'b0 || hits !== 3'd0)
            $display("FAIL reset_state: rdy/fs/x/xv/busy/done=%b hits=%0d want 000000 hits=0",
                     {load_ready, frame_start, x, x_valid, busy, done}, hits);
        else passed++;
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (load_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release: rdy=%b busy=%b want 1 0", load_ready, busy);
        else passed++;
    endtask

    task automatic test_directed();
        do_frame(8'h00, "w00");
        do_frame(8'hAA, "wAA");
        do_frame(8'h33, "w33");
        do_frame(8'h07, "w07");
        do_frame(8'hFF, "wFF");
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            do_frame(8'($urandom), "rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] data [0:33];
        logic [7:0] w;
        int ph;
        for (int c = 0; c < 34; c++) data[c] = 8'($urandom);
        wait_ready("b2b");
        for (int c = 0; c < 33; c++) begin
            load_valid = 1'b1;
            load_data  = data[c];
            ph = c % 11;
            w  = data[c - ph];
            total++;
            if (load_ready !== (ph == 0) || busy !== (ph != 0) || frame_start !== (ph == 1))
                $display("FAIL b2b_ctrl c%0d: rdy/busy/fs=%b%b%b want %b%b%b", c, load_ready, busy, frame_start,
                         ph == 0, ph != 0, ph == 1);
            else passed++;
            total++;
            if (ph >= 2 && ph <= 9) begin
                if (x_valid !== 1'b1 || x !== w[ph-2])
                    $display("FAIL b2b_bit c%0d: xv=%b x=%b want 1 %b", c, x_valid, x, w[ph-2]);
                else passed++;
            end else if (x_valid !== 1'b0 || x !== 1'b0) begin
                $display("FAIL b2b_idle_x c%0d: xv=%b x=%b want 0 0", c, x_valid, x);
            end else passed++;
            total++;
            if (done !== (ph == 10) || (ph == 10 && hits !== 3'(model_hits(w))))
                $display("FAIL b2b_done c%0d: done=%b hits=%0d want %b hits=%0d", c, done, hits, ph == 10, model_hits(w));
            else passed++;
            @(negedge clock);
        end
        load_valid = 1'b0;
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || frame_start !== 1'b0)
            $display("FAIL b2b_stop: busy=%b fs=%b want 0 0", busy, frame_start);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        int seen_done = 0;
        w = 8'($urandom);
        wait_ready("midrst");
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clock);
        load_valid = 1'b0;
        repeat (4) @(negedge clock);
        total++;
        if (x_valid !== 1'b1 || x !== w[3])
            $display("FAIL midrst_shift4: xv=%b x=%b want 1 %b", x_valid, x, w[3]);
        else passed++;
        reset = 1'b0;
        @(negedge clock);
        total++;
        if ({x_valid, x, done, busy, load_ready, frame_start} !== 6'b0 || hits !== 3'd0)
            $display("FAIL midrst_abort: xv/x/done/busy/rdy/fs=%b hits=%0d want 000000 hits=0",
                     {x_valid, x, done, busy, load_ready, frame_start}, hits);
        else passed++;
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (load_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL midrst_release: rdy=%b busy=%b want 1 0", load_ready, busy);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (done === 1'b1 || x_valid === 1'b1) seen_done++;
        end
        total++;
        if (seen_done != 0)
            $display("FAIL midrst_quiet: %0d cycles with done/x_valid, want 0", seen_done);
        else passed++;
        do_frame(8'($urandom), "postrst");
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
